// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default sizing for the fetch/execute SRAM port arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_INST = 2'd1,
        TAG_DATA = 2'd2
    } arb_tag_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data wins while fetch is waiting.
module arb_starve_ctr #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign at_max = (count_reg == CNT_W'(MAX));
    assign count  = count_reg;

    // Clear takes precedence: a fetch grant or an idle fetch ends the starvation run.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !at_max) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and load/store,
// data first, with a starvation guard so fetch always progresses.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_cancel,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic             at_max;
    logic [CNT_W-1:0] starve_cnt;
    logic             data_win;
    logic             inst_win;
    arb_tag_t         tag_reg;
    arb_tag_t         tag_next;

    // Data normally wins; a saturated starvation count hands the port to fetch.
    assign data_win = data_req & ~(inst_req & at_max);
    assign inst_win = inst_req & ~data_win;
    assign inst_gnt = inst_win & ~reset;
    assign data_gnt = data_win & ~reset;

    arb_starve_ctr #(
        .MAX   (STARVE_MAX),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (data_gnt & inst_req),
        .clr    (inst_gnt | ~inst_req),
        .count  (starve_cnt),
        .at_max (at_max)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (data_gnt) begin
            mem_en    = 1'b1;
            mem_we    = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (inst_gnt) begin
            mem_en   = 1'b1;
            mem_addr = inst_addr;
        end
    end

    // Stores complete at grant, so only reads leave a tag for the response cycle.
    always_comb begin
        tag_next = TAG_NONE;
        if (inst_gnt) begin
            tag_next = TAG_INST;
        end else if (data_gnt && (data_wstrb == '0)) begin
            tag_next = TAG_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg <= TAG_NONE;
        end else begin
            tag_reg <= tag_next;
        end
    end

    assign inst_rvalid = (tag_reg == TAG_INST) & ~inst_cancel & ~reset;
    assign data_rvalid = (tag_reg == TAG_DATA) & ~reset;
    assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
    assign data_rdata  = data_rvalid ? mem_rdata : '0;

    starve_cnt_bounded: assert property (@(posedge clk) disable iff (reset)
        starve_cnt <= CNT_W'(STARVE_MAX));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: fetch, contention, store, cancel, reset, back-to-back.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_cancel (inst_cancel),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge, then inputs may be driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Let combinational outputs settle well before the next edge, and log the cycle.
    task automatic sample();
        #3;
        $display("cyc %0d: ig=%0b dg=%0b en=%0b we=%0h addr=%08h iv=%0b ir=%08h dv=%0b dr=%08h",
                 cyc, inst_gnt, data_gnt, mem_en, mem_we, mem_addr,
                 inst_rvalid, inst_rdata, data_rvalid, data_rdata);
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        inst_cancel = 1'b0;
        data_req    = 1'b0;
        data_wstrb  = 4'h0;
    endtask

    initial begin
        reset       = 1'b1;
        inst_req    = 1'b1;
        inst_addr   = 32'h0;
        inst_cancel = 1'b0;
        data_req    = 1'b1;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_rdata   = 32'h0;

        // Reset with both requesting: everything held quiet.
        next_cycle();
        sample();
        check("rst_inst_gnt", inst_gnt, 0);
        check("rst_data_gnt", data_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        next_cycle();
        sample();
        check("rst_inst_rvalid", inst_rvalid, 0);
        check("rst_data_rvalid", data_rvalid, 0);

        // Fetch only.
        next_cycle();
        reset     = 1'b0;
        idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000000;
        sample();
        check("fetch_gnt", inst_gnt, 1);
        check("fetch_dgnt", data_gnt, 0);
        check("fetch_en", mem_en, 1);
        check("fetch_addr", mem_addr, 32'h1c000000);
        check("fetch_we", mem_we, 0);
        next_cycle();
        idle();
        mem_rdata = 32'h02800c0c;
        sample();
        check("fetch_rvalid", inst_rvalid, 1);
        check("fetch_rdata", inst_rdata, 32'h02800c0c);
        check("fetch_drvalid", data_rvalid, 0);
        check("fetch_idle_en", mem_en, 0);

        // Contention: data wins cycles 0-3, fetch cycle 4, data cycle 5.
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            idle();
            if (k < 6) begin
                inst_req  = 1'b1;
                inst_addr = 32'h1c000004;
                data_req  = 1'b1;
                data_addr = 32'h00000200;
            end
            mem_rdata = 32'h1000 + k;
            sample();
            check("cont_inst_gnt", inst_gnt, (k == 4));
            check("cont_data_gnt", data_gnt, (k < 6) && (k != 4));
            check("cont_inst_rvalid", inst_rvalid, (k == 5));
            check("cont_data_rvalid", data_rvalid, (k >= 1) && (k != 5));
            if (k == 5) check("cont_inst_rdata", inst_rdata, 32'h1005);
            if (k == 6) check("cont_data_rdata", data_rdata, 32'h1006);
        end

        // Store: strobes and data driven, no response.
        next_cycle();
        idle();
        data_req   = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h100;
        data_wdata = 32'hdeadbeef;
        sample();
        check("st_gnt", data_gnt, 1);
        check("st_we", mem_we, 4'b0011);
        check("st_addr", mem_addr, 32'h100);
        check("st_wdata", mem_wdata, 32'hdeadbeef);
        next_cycle();
        idle();
        mem_rdata = 32'h55aa55aa;
        sample();
        check("st_no_drvalid", data_rvalid, 0);
        check("st_no_irvalid", inst_rvalid, 0);

        // Cancel the outstanding fetch.
        next_cycle();
        idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000010;
        sample();
        check("can_gnt", inst_gnt, 1);
        next_cycle();
        idle();
        inst_cancel = 1'b1;
        mem_rdata   = 32'h11111111;
        sample();
        check("can_rvalid", inst_rvalid, 0);
        check("can_rdata", inst_rdata, 0);

        // Cancel alongside a new fetch grant: old dropped, new kept.
        next_cycle();
        idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000020;
        sample();
        check("can2_gnt0", inst_gnt, 1);
        next_cycle();
        idle();
        inst_req    = 1'b1;
        inst_cancel = 1'b1;
        inst_addr   = 32'h1c000024;
        mem_rdata   = 32'h22222222;
        sample();
        check("can2_gnt1", inst_gnt, 1);
        check("can2_old_rvalid", inst_rvalid, 0);
        next_cycle();
        idle();
        mem_rdata = 32'h33333333;
        sample();
        check("can2_new_rvalid", inst_rvalid, 1);
        check("can2_new_rdata", inst_rdata, 32'h33333333);

        // Build up starvation count to 4, then reset during a data load.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            idle();
            inst_req  = 1'b1;
            data_req  = 1'b1;
            data_addr = 32'h300;
            sample();
            check("pre_rst_dgnt", data_gnt, 1);
        end
        next_cycle();
        reset = 1'b1;
        sample();
        check("mid_rst_drvalid", data_rvalid, 0);
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_gnt", inst_gnt | data_gnt, 0);
        // Cleared counter: data wins four more times before fetch gets in.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            reset = 1'b0;
            sample();
            check("post_rst_dgnt", data_gnt, (k != 4));
            check("post_rst_ignt", inst_gnt, (k == 4));
            if (k == 0) check("post_rst_drvalid", data_rvalid, 0);
        end

        // Load then fetch back-to-back, each response to its own owner.
        next_cycle();
        idle();
        data_req  = 1'b1;
        data_addr = 32'h400;
        mem_rdata = 32'h0;
        sample();
        check("b2b_dgnt", data_gnt, 1);
        next_cycle();
        idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000008;
        mem_rdata = 32'haaaa0001;
        sample();
        check("b2b_ignt", inst_gnt, 1);
        check("b2b_drvalid", data_rvalid, 1);
        check("b2b_drdata", data_rdata, 32'haaaa0001);
        check("b2b_irvalid0", inst_rvalid, 0);
        next_cycle();
        idle();
        mem_rdata = 32'hbbbb0002;
        sample();
        check("b2b_irvalid", inst_rvalid, 1);
        check("b2b_irdata", inst_rdata, 32'hbbbb0002);
        check("b2b_drvalid1", data_rvalid, 0);
        check("b2b_drdata1", data_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
